// File: rtl/mips32_pkg.sv
// MIPS32 shared constants: opcodes, word width, fetch FSM states.
// Imported by the fetch unit and its instruction buffer.
package mips32_pkg;

  localparam int WORD_W = 32;

  localparam logic [5:0] OP_ADD   = 6'h00;
  localparam logic [5:0] OP_SUB   = 6'h01;
  localparam logic [5:0] OP_AND   = 6'h02;
  localparam logic [5:0] OP_OR    = 6'h03;
  localparam logic [5:0] OP_SLT   = 6'h04;
  localparam logic [5:0] OP_MUL   = 6'h05;
  localparam logic [5:0] OP_LW    = 6'h08;
  localparam logic [5:0] OP_SW    = 6'h09;
  localparam logic [5:0] OP_ADDI  = 6'h0a;
  localparam logic [5:0] OP_SUBI  = 6'h0b;
  localparam logic [5:0] OP_SLTI  = 6'h0c;
  localparam logic [5:0] OP_BNEQZ = 6'h0d;
  localparam logic [5:0] OP_BEQZ  = 6'h0e;
  localparam logic [5:0] OP_HLT   = 6'h3f;

  typedef enum logic [1:0] {
    RUN,
    STOP,
    HALT
  } fetch_state_t;

  function automatic logic is_hlt(
    input logic [WORD_W-1:0] w
  );
    return w[31:26] == OP_HLT;
  endfunction

endpackage

// File: rtl/mips32_fetch_fifo.sv
// IF/ID instruction buffer: power-of-two FIFO with flush.
// Flush and reset win over push/pop in the same cycle.
module mips32_fetch_fifo
  import mips32_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int W     = WORD_W + 32,
  localparam int CW   = $clog2(DEPTH + 1),
  localparam int PW   = $clog2(DEPTH)
) (
  input  logic          clk1,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wp;
  logic [PW-1:0] rp;
  logic          do_push;
  logic          do_pop;

  assign full    = count == CW'(DEPTH);
  assign empty   = count == '0;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rp];

  // pointers and occupancy
  always_ff @(posedge clk1) begin
    if (rst || flush) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + PW'(1);
      if (do_pop)  rp <= rp + PW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // storage array
  always_ff @(posedge clk1) begin
    if (do_push && !flush && !rst) mem[wp] <= din;
  end

endmodule

// File: rtl/mips32_fetch_unit.sv
// MIPS32 IF stage: word-addressed fetch, IF/ID buffer, RUN/STOP/HALT FSM.
// Optional fetch_cnt transfer counter under `FETCH_PERF_CNT_EN.
module mips32_fetch_unit
  import mips32_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int AW    = 32
) (
  input  logic              clk1,
  input  logic              rst,
  output logic              imem_req,
  output logic [AW-1:0]     imem_addr,
  input  logic [WORD_W-1:0] imem_rdata,
  input  logic              br_taken,
  input  logic [AW-1:0]     br_target,
  input  logic              halt,
  output logic              id_valid,
  input  logic              id_ready,
  output logic [WORD_W-1:0] id_ir,
  output logic [AW-1:0]     id_npc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]       fetch_cnt
`endif
);

  localparam int FW = WORD_W + AW;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int OW = CW + 1;

  fetch_state_t  state;
  logic [AW-1:0] pc;
  logic          fl_vld;
  logic          push;
  logic          pop;
  logic          fire;
  logic          flush;
  logic          hlt_now;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;
  logic [OW-1:0] occ;
  logic [FW-1:0] fifo_out;

  // The read returns while pc already holds fetch address + 1,
  // so pc is exactly the NPC to pair with the arriving word.
  assign flush   = br_taken && state != HALT;
  assign push    = fl_vld && !br_taken && !halt && state != HALT;
  assign hlt_now = push && is_hlt(imem_rdata);
  assign fire    = id_valid && id_ready;
  assign pop     = fire;

  // A same-cycle pop frees a slot, so back-to-back requests can stream.
  assign occ = OW'(count) + OW'(fl_vld) - OW'(pop);

  assign imem_req = !rst && state == RUN && !halt && !br_taken
                 && !hlt_now && !full && occ < OW'(DEPTH);
  assign imem_addr = pc;

  assign id_valid = !rst && !empty && !halt && state != HALT;
  assign id_ir    = fifo_out[FW-1:AW];
  assign id_npc   = fifo_out[AW-1:0];

  mips32_fetch_fifo #(
    .DEPTH (DEPTH),
    .W     (FW)
  ) u_fifo (
    .clk1  (clk1),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .din   ({imem_rdata, pc}),
    .dout  (fifo_out),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // PC, in-flight tracking and fetch FSM
  always_ff @(posedge clk1) begin
    if (rst) begin
      state  <= RUN;
      pc     <= '0;
      fl_vld <= 1'b0;
    end else begin
      fl_vld <= imem_req;
      if (flush)         pc <= br_target;
      else if (imem_req) pc <= pc + AW'(1);
      if (halt || state == HALT) state <= HALT;
      else if (br_taken)         state <= RUN;
      else if (hlt_now)          state <= STOP;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  // count accepted transfers; a pop discarded by a redirect is not one
  always_ff @(posedge clk1) begin
    if (rst)                    fetch_cnt <= '0;
    else if (fire && !br_taken) fetch_cnt <= fetch_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_mips32_fetch_unit.sv
// Directed bench for mips32_fetch_unit: streaming, stall, redirect,
// HLT stop, halt and reset, with a one-cycle-latency memory model.
module tb_mips32_fetch_unit;

  localparam int DEPTH = 2;
  localparam int AW    = 32;
  localparam logic [31:0] HLTW = 32'hfc000000;

  logic          clk1 = 1'b0;
  logic          rst = 1'b1;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_rdata;
  logic          br_taken = 1'b0;
  logic [AW-1:0] br_target = '0;
  logic          halt = 1'b0;
  logic          id_valid;
  logic          id_ready = 1'b0;
  logic [31:0]   id_ir;
  logic [AW-1:0] id_npc;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0]   fetch_cnt;
`endif

  mips32_fetch_unit #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) dut (
    .clk1       (clk1),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .halt       (halt),
    .id_valid   (id_valid),
    .id_ready   (id_ready),
    .id_ir      (id_ir),
    .id_npc     (id_npc)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_cnt  (fetch_cnt)
`endif
  );

  always #5 clk1 = ~clk1;

  logic [31:0] mem [0:255];

  always @(posedge clk1) begin
    if (imem_req) imem_rdata <= mem[imem_addr[7:0]];
  end

  typedef struct packed {
    logic [31:0] ir;
    logic [31:0] npc;
  } del_t;

  int          cyc = 0;
  int          rq_cyc[$];
  logic [31:0] rq_addr[$];
  del_t        dq[$];

  always @(posedge clk1) cyc <= cyc + 1;

  always @(negedge clk1) begin
    if (imem_req) begin
      rq_cyc.push_back(cyc);
      rq_addr.push_back(imem_addr);
    end
    if (id_valid && id_ready && !br_taken)
      dq.push_back('{ir: id_ir, npc: id_npc});
  end

  int ntests = 0;
  int nfail  = 0;
  int rb, db, base;

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk1);
    #1;
  endtask

  task automatic reset_phase(input string nm);
    rst = 1'b1;
    br_taken = 1'b0;
    halt = 1'b0;
    @(negedge clk1);
    check({nm, "_rst_req"}, 64'(imem_req), 64'd0);
    check({nm, "_rst_valid"}, 64'(id_valid), 64'd0);
    tick();
    rst = 1'b0;
    rb = rq_addr.size();
    db = dq.size();
    base = cyc;
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] ir;
    logic [31:0] npc;
  } vec_t;

  vec_t va[3];

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    bit found;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0c000000 + 32'(i);
    mem[0]   = 32'h28010078;
    mem[1]   = 32'h0c631800;
    mem[2]   = 32'h20220000;
    mem[3]   = 32'h33333333;
    mem[7]   = HLTW;
    mem[125] = HLTW;

    va[0] = '{addr: 32'd0, ir: 32'h28010078, npc: 32'd1};
    va[1] = '{addr: 32'd1, ir: 32'h0c631800, npc: 32'd2};
    va[2] = '{addr: 32'd2, ir: 32'h20220000, npc: 32'd3};

    // streaming with decode always ready
    id_ready = 1'b1;
    reset_phase("A");
    repeat (8) tick();
    check("A_nreq", 64'(rq_addr.size() - rb >= 3), 64'd1);
    check("A_ndel", 64'(dq.size() - db >= 3), 64'd1);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("A_addr%0d", i), 64'(rq_addr[rb+i]), 64'(va[i].addr));
      check($sformatf("A_cyc%0d", i), 64'(rq_cyc[rb+i] - base), 64'(i));
      check($sformatf("A_ir%0d", i), 64'(dq[db+i].ir), 64'(va[i].ir));
      check($sformatf("A_npc%0d", i), 64'(dq[db+i].npc), 64'(va[i].npc));
    end

    // decode stalled for five cycles
    id_ready = 1'b0;
    reset_phase("B");
    for (int k = 0; k < 5; k++) begin
      @(negedge clk1);
      if (k >= 2) begin
        check($sformatf("B_req%0d", k), 64'(imem_req), 64'd0);
        check($sformatf("B_vld%0d", k), 64'(id_valid), 64'd1);
        check($sformatf("B_ir%0d", k), 64'(id_ir), 64'(va[0].ir));
        check($sformatf("B_npc%0d", k), 64'(id_npc), 64'd1);
      end
      tick();
    end
    check("B_nreq_stall", 64'(rq_addr.size() - rb), 64'(DEPTH));
    id_ready = 1'b1;
    repeat (8) tick();
    check("B_ndel", 64'(dq.size() - db >= 3), 64'd1);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("B_dir%0d", i), 64'(dq[db+i].ir), 64'(va[i].ir));
      check($sformatf("B_dnpc%0d", i), 64'(dq[db+i].npc), 64'(va[i].npc));
    end

    // redirect to 120 while the read of address 3 is in flight
    id_ready = 1'b1;
    reset_phase("C");
    repeat (4) tick();
    br_taken = 1'b1;
    br_target = 32'd120;
    @(negedge clk1);
    check("C_req_redirect", 64'(imem_req), 64'd0);
    tick();
    br_taken = 1'b0;
    repeat (15) tick();
    check("C_nreq", 64'(rq_addr.size() - rb), 64'd10);
    check("C_addr3", 64'(rq_addr[rb+3]), 64'd3);
    check("C_addr_br", 64'(rq_addr[rb+4]), 64'd120);
    check("C_ndel", 64'(dq.size() - db), 64'd8);
    check("C_br_ir", 64'(dq[db+2].ir), 64'(mem[120]));
    check("C_br_npc", 64'(dq[db+2].npc), 64'd121);
    found = 1'b0;
    for (int i = db; i < dq.size(); i++)
      if (dq[i].ir == mem[3] || dq[i].ir == mem[2]) found = 1'b1;
    check("C_squashed_hidden", 64'(found), 64'd0);
    check("C_last_npc", 64'(dq[dq.size()-1].npc), 64'd126);
`ifdef FETCH_PERF_CNT_EN
    check("C_fetch_cnt", 64'(fetch_cnt), 64'd8);
`endif

    // HLT word at address 7 stops fetch, branch resumes
    id_ready = 1'b1;
    reset_phase("D");
    repeat (14) tick();
    check("D_nreq", 64'(rq_addr.size() - rb), 64'd8);
    found = 1'b0;
    for (int i = rb; i < rq_addr.size(); i++)
      if (rq_addr[i] == 32'd8) found = 1'b1;
    check("D_no_req8", 64'(found), 64'd0);
    check("D_ndel", 64'(dq.size() - db), 64'd8);
    check("D_hlt_ir", 64'(dq[dq.size()-1].ir), 64'(HLTW));
    check("D_hlt_npc", 64'(dq[dq.size()-1].npc), 64'd8);
    br_taken = 1'b1;
    br_target = 32'd0;
    @(negedge clk1);
    check("D_req_in_br", 64'(imem_req), 64'd0);
    tick();
    br_taken = 1'b0;
    @(negedge clk1);
    check("D_resume_req", 64'(imem_req), 64'd1);
    check("D_resume_addr", 64'(imem_addr), 64'd0);
    tick();

    // halt pulse mid-stream, then reset restarts at 0
    id_ready = 1'b1;
    reset_phase("E");
    repeat (3) tick();
    halt = 1'b1;
    @(negedge clk1);
    check("E_halt_vld", 64'(id_valid), 64'd0);
    check("E_halt_req", 64'(imem_req), 64'd0);
    tick();
    halt = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk1);
      check($sformatf("E_vld%0d", k), 64'(id_valid), 64'd0);
      check($sformatf("E_req%0d", k), 64'(imem_req), 64'd0);
      tick();
    end
    reset_phase("E2");
    @(negedge clk1);
    check("E2_req", 64'(imem_req), 64'd1);
    check("E2_addr", 64'(imem_addr), 64'd0);
    tick();

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
